// File: rtl/router_fifo_pkg.sv
// ---------------------------------------------------------------------------
// router_fifo_pkg
// Shared constants for the 1x3 router output buffers:
//   - stream width and buffer depth
//   - header field positions (payload length in [7:2], address in [1:0])
//   - packet counter width
//   - a helper that turns a header length field into the starting packet count
// No ports (package).
// ---------------------------------------------------------------------------
package router_fifo_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int FIFO_DEPTH    = 16;
    localparam int ADDR_WIDTH    = $clog2(FIFO_DEPTH);

    localparam int LEN_MSB       = 7;
    localparam int LEN_LSB       = 2;
    localparam int ADDR_MSB      = 1;
    localparam int ADDR_LSB      = 0;
    localparam int LEN_WIDTH     = LEN_MSB - LEN_LSB + 1;

    localparam int PKT_CNT_WIDTH = 7;

    // Bytes still to come after a header: the payload plus one parity byte.
    function automatic logic [PKT_CNT_WIDTH-1:0] hdr_pkt_cnt(
        input logic [LEN_WIDTH-1:0] len_field
    );
        return PKT_CNT_WIDTH'(len_field) + PKT_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// ---------------------------------------------------------------------------
// router_fifo_mem
// Storage array for one router output buffer.
// Writes are synchronous; reads are asynchronous so the top can decide
// what to register on the read edge.
// Ports:
//   clock      in   rising-edge write clock
//   i_wr_en    in   write strobe (already qualified by the caller)
//   i_wr_addr  in   write index
//   i_wr_data  in   entry to store
//   i_rd_addr  in   read index
//   o_rd_data  out  entry at i_rd_addr (combinational)
// ---------------------------------------------------------------------------
module router_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Array write; contents are never cleared, the pointers define validity.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/router_fifo.sv
// ---------------------------------------------------------------------------
// router_fifo
// Per-port output buffer of the 1x3 router. Stores {header flag, byte}
// entries, returns them one per read, and tracks the remaining length of the
// packet being read so data_out drops back to 0 once a packet has drained.
// Ports:
//   clock       in   single clock, rising edge
//   resetn      in   synchronous active-low reset
//   soft_reset  in   synchronous active-high flush (synchronizer timeout)
//   write_enb   in   write strobe for this port
//   lfd_state   in   data_in is a header byte
//   data_in     in   packet byte ([7:2] length, [1:0] address on a header)
//   read_enb    in   destination read strobe
//   data_out    out  registered read data
//   full        out  all entries occupied (combinational from pointers)
//   empty       out  no entries occupied (combinational from pointers)
// ---------------------------------------------------------------------------
module router_fifo
    import router_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = router_fifo_pkg::DATA_WIDTH,
    parameter int DEPTH      = router_fifo_pkg::FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]              PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [PKT_CNT_WIDTH-1:0] CNT_ONE = {{(PKT_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [AW:0]              r_wr_ptr;
    logic [AW:0]              r_rd_ptr;
    logic [PKT_CNT_WIDTH-1:0] r_pkt_cnt;
    logic [DATA_WIDTH-1:0]    r_data_out;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_flush;
    logic                     w_wr_accept;
    logic                     w_rd_accept;
    logic [DATA_WIDTH:0]      w_wr_entry;
    logic [DATA_WIDTH:0]      w_rd_entry;
    logic                     w_rd_hdr;
    logic [DATA_WIDTH-1:0]    w_rd_byte;

    // The extra MSB on each pointer separates "same slot, same lap" (empty)
    // from "same slot, writer one lap ahead" (full).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Flush wins over any same-cycle read or write.
    assign w_flush     = !resetn || soft_reset;
    assign w_wr_accept = write_enb && !w_full  && !w_flush;
    assign w_rd_accept = read_enb  && !w_empty && !w_flush;

    assign w_wr_entry = {lfd_state, data_in};
    assign w_rd_hdr   = w_rd_entry[DATA_WIDTH];
    assign w_rd_byte  = w_rd_entry[DATA_WIDTH-1:0];

    router_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock     (clock),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_entry)
    );

    // Write pointer; wraps naturally at 2*DEPTH.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_wr_ptr <= {(AW+1){1'b0}};
        end else if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // Read pointer; wraps naturally at 2*DEPTH.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_rd_ptr <= {(AW+1){1'b0}};
        end else if (w_rd_accept) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end else begin
            r_rd_ptr <= r_rd_ptr;
        end
    end

    // Remaining bytes of the packet being read: loaded from each header,
    // counted down on every non-header byte until it reaches zero.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_pkt_cnt <= {PKT_CNT_WIDTH{1'b0}};
        end else if (w_rd_accept) begin
            if (w_rd_hdr) begin
                r_pkt_cnt <= hdr_pkt_cnt(w_rd_byte[LEN_MSB:LEN_LSB]);
            end else if (r_pkt_cnt != {PKT_CNT_WIDTH{1'b0}}) begin
                r_pkt_cnt <= r_pkt_cnt - CNT_ONE;
            end else begin
                r_pkt_cnt <= r_pkt_cnt;
            end
        end else begin
            r_pkt_cnt <= r_pkt_cnt;
        end
    end

    // Read data register; returns to 0 on an idle edge once the packet is done,
    // otherwise holds the last byte while the destination pauses mid-packet.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_data_out <= {DATA_WIDTH{1'b0}};
        end else if (w_rd_accept) begin
            r_data_out <= w_rd_byte;
        end else if (r_pkt_cnt == {PKT_CNT_WIDTH{1'b0}}) begin
            r_data_out <= {DATA_WIDTH{1'b0}};
        end else begin
            r_data_out <= r_data_out;
        end
    end

    assign data_out = r_data_out;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule

// File: tb/tb_router_fifo.sv
// ---------------------------------------------------------------------------
// tb_router_fifo
// Self-checking bench for router_fifo: a queue-based model of the buffer is
// updated on every rising edge and compared against full/empty/data_out on
// every falling edge; directed scenarios add literal expectations, followed
// by randomized traffic with occasional soft and hard resets.
// ---------------------------------------------------------------------------
module tb_router_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clock      = 1'b0;
    logic          resetn     = 1'b0;
    logic          soft_reset = 1'b0;
    logic          write_enb  = 1'b0;
    logic          lfd_state  = 1'b0;
    logic [DW-1:0] data_in    = 8'h00;
    logic          read_enb   = 1'b0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    router_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    logic [DW:0]   m_q[$];
    int            m_cnt  = 0;
    logic [DW-1:0] m_dout = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: what the buffer must look like after this edge.
    task automatic model_edge();
        logic [DW:0] e;
        bit rd;
        bit wr;
        if (!resetn || soft_reset) begin
            m_q.delete();
            m_cnt  = 0;
            m_dout = 8'h00;
        end else begin
            rd = read_enb  && (m_q.size() != 0);
            wr = write_enb && (m_q.size() != DEPTH);
            if (rd) begin
                e = m_q.pop_front();
                m_dout = e[DW-1:0];
                if (e[DW]) m_cnt = int'(e[7:2]) + 1;
                else if (m_cnt != 0) m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                m_dout = 8'h00;
            end
            if (wr) m_q.push_back({lfd_state, data_in});
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_edge();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (check_en) begin
                chk("empty",    {31'd0, empty}, {31'd0, m_q.size() == 0});
                chk("full",     {31'd0, full},  {31'd0, m_q.size() == DEPTH});
                chk("data_out", {24'd0, data_out}, {24'd0, m_dout});
            end
        end
    end

    // Drive one cycle of inputs (from a falling edge to the next one).
    task automatic step(input bit we, input bit lfd, input logic [DW-1:0] d,
                        input bit re, input bit sr = 1'b0);
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = d;
        read_enb   = re;
        soft_reset = sr;
        @(negedge clock);
    endtask

    initial begin
        int wp[4];
        int rp[4];
        wp = '{70, 30, 50, 90};
        rp = '{30, 70, 50, 90};

        // Reset then idle
        @(negedge clock);
        resetn = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check_en = 1'b1;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full",  {31'd0, full},  32'd0);
        chk("rst_dout",  {24'd0, data_out}, 32'd0);
        resetn = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("rd_empty_empty", {31'd0, empty}, 32'd1);

        // Single packet: header 0D (length 3, addr 1), 3 payload, parity A5
        step(1'b1, 1'b1, 8'h0D, 1'b0);
        chk("wr_empty_fall", {31'd0, empty}, 32'd0);
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("pkt_hdr", {24'd0, data_out}, 32'h0D);
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("pkt_p0",  {24'd0, data_out}, 32'h11);
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("pkt_p1",  {24'd0, data_out}, 32'h22);
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("pkt_p2",  {24'd0, data_out}, 32'h33);
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("pkt_par", {24'd0, data_out}, 32'hA5);
        step(1'b0, 1'b0, 8'h00, 1'b0); chk("pkt_end", {24'd0, data_out}, 32'h00);

        // Fill / overflow
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
            if (i == 14) chk("fill_not_full", {31'd0, full}, 32'd0);
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        step(1'b1, 1'b0, 8'hEE, 1'b0);
        chk("ovf_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("fill_order", {24'd0, data_out}, 32'h40 + i);
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("drain_idle_dout", {24'd0, data_out}, 32'h00);

        // Simultaneous read/write at occupancy 8, across pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 8'(8'h90 + i), 1'b1);
            chk("rw_order", {24'd0, data_out}, (i < 8) ? (32'h80 + i) : (32'h90 + i - 8));
        end
        chk("rw_occ", m_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("rw_tail", {24'd0, data_out}, 32'h90 + 12 + i);
        end

        // Soft reset mid-packet: header length 10 (8'h2A), 4 payload bytes
        step(1'b1, 1'b1, 8'h2A, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'hC1 + i), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("sr_hdr", {24'd0, data_out}, 32'h2A);
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("sr_p0",  {24'd0, data_out}, 32'hC1);
        step(1'b0, 1'b0, 8'h00, 1'b0); chk("sr_hold", {24'd0, data_out}, 32'hC1);
        step(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
        chk("sr_empty", {31'd0, empty}, 32'd1);
        chk("sr_dout",  {24'd0, data_out}, 32'h00);
        step(1'b1, 1'b1, 8'h04, 1'b0);
        step(1'b1, 1'b0, 8'h77, 1'b0);
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("fresh_hdr", {24'd0, data_out}, 32'h04);
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("fresh_p0",  {24'd0, data_out}, 32'h77);
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("fresh_par", {24'd0, data_out}, 32'h5A);
        step(1'b0, 1'b0, 8'h00, 1'b0); chk("fresh_end", {24'd0, data_out}, 32'h00);

        // Read and write together while full: write dropped
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'hB0 + i), 1'b0);
        chk("edge_full", {31'd0, full}, 32'd1);
        step(1'b1, 1'b0, 8'hFF, 1'b1);
        chk("edge_full_fall", {31'd0, full}, 32'd0);
        chk("edge_dout", {24'd0, data_out}, 32'hB0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("edge_order", {24'd0, data_out}, 32'hB0 + i);
        end
        chk("edge_empty", {31'd0, empty}, 32'd1);

        // Randomized traffic with occasional flushes
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 500; c++) begin
                resetn = ($urandom_range(0, 299) != 0);
                step($urandom_range(0, 99) < wp[seg],
                     $urandom_range(0, 7) == 0,
                     8'($urandom),
                     $urandom_range(0, 99) < rp[seg],
                     $urandom_range(0, 99) == 0);
            end
        end
        resetn = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
